// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and memory.
// The arbiter takes the slave view; masters and memory take the master view.
interface dmem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the core and debug.
// Define ROUND_ROBIN_EN for round-robin ties; default is fixed cpu priority.
module dmem_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("dmem_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic          cpu_win;
    logic          dbg_win;

`ifdef ROUND_ROBIN_EN
    logic          last_q, last_d;
`endif

    // Pick at most one winner, only in IDLE and never while in reset
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (state_q == S_IDLE && reset) begin
`ifdef ROUND_ROBIN_EN
            if (bus.cpu_req && bus.dbg_req) begin
                cpu_win = (last_q == OWN_DBG);
                dbg_win = (last_q == OWN_CPU);
            end else begin
                cpu_win = bus.cpu_req;
                dbg_win = bus.dbg_req;
            end
`else
            cpu_win = bus.cpu_req;
            dbg_win = bus.dbg_req && !bus.cpu_req;
`endif
        end
    end

    assign bus.cpu_gnt = cpu_win;
    assign bus.dbg_gnt = dbg_win;

    // Sequence one access: latch winner, strobe memory, wait, respond
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
`ifdef ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cpu_win || dbg_win) begin
                    owner_d     = dbg_win ? OWN_DBG : OWN_CPU;
                    we_d        = dbg_win ? bus.dbg_we : bus.cpu_we;
                    mem_addr_d  = dbg_win ? bus.dbg_addr : bus.cpu_addr;
                    mem_wdata_d = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    state_d     = S_ACCESS;
`ifdef ROUND_ROBIN_EN
                    last_d      = dbg_win ? OWN_DBG : OWN_CPU;
`endif
                end
            end
            S_ACCESS: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                    cpu_rvalid_d = (owner_q == OWN_CPU);
                    dbg_rvalid_d = (owner_q == OWN_DBG);
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
`ifdef ROUND_ROBIN_EN
            last_q       <= OWN_DBG;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
`ifdef ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a MEM_LAT=1 instance for most
// directed cases and a MEM_LAT=3 instance for the latency case.
module tb_dmem_arbiter;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.DW(32), .AW(32)) bus ();
    dmem_arbiter_if #(.DW(32), .AW(32)) bus3 ();

    dmem_arbiter #(.DW(32), .AW(32), .MEM_LAT(LAT)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    dmem_arbiter #(.DW(32), .AW(32), .MEM_LAT(LAT3)) u_dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus3)
    );

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        dbg;
        logic [31:0] rdata;
    } rsp_exp_t;

    mem_exp_t mq[$];
    rsp_exp_t rq[$];
    mem_exp_t mq3[$];
    rsp_exp_t rq3[$];

    logic [31:0] shadow [0:63];
    logic [31:0] last_rd_cpu = 32'h0;
    logic [31:0] last_rd_dbg = 32'h0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Memory model for the LAT=1 instance: data valid only LAT cycles
    // after mem_en, garbage otherwise
    logic [31:0] mem [0:63];
    int          rd_cnt = 0;
    logic [5:0]  rd_idx = 6'd0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 20) ? 32'h12345678 : (32'hA5000000 | 32'(i));
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        if (bus.mem_en && !bus.mem_we) begin
            rd_cnt <= 1;
            rd_idx <= bus.mem_addr[7:2];
        end else if (rd_cnt != 0 && rd_cnt <= LAT) begin
            rd_cnt <= rd_cnt + 1;
        end else begin
            rd_cnt <= 0;
        end
    end

    assign bus.mem_rdata = (rd_cnt == LAT) ? mem[rd_idx] : 32'hDEADBEEF;

    // Memory model for the LAT=3 instance: returns C0DE0000 | addr
    int          rd_cnt3 = 0;
    logic [15:0] rd_addr3 = 16'h0;

    always @(posedge clk) begin
        if (bus3.mem_en && !bus3.mem_we) begin
            rd_cnt3  <= 1;
            rd_addr3 <= bus3.mem_addr[15:0];
        end else if (rd_cnt3 != 0 && rd_cnt3 <= LAT3) begin
            rd_cnt3 <= rd_cnt3 + 1;
        end else begin
            rd_cnt3 <= 0;
        end
    end

    assign bus3.mem_rdata = (rd_cnt3 == LAT3) ?
                            (32'hC0DE0000 | {16'h0, rd_addr3}) : 32'hDEADBEEF;

    // Monitor for the LAT=1 instance
    always @(negedge clk) begin
        mem_exp_t me;
        rsp_exp_t re;
        if (rst_n) begin
            if (bus.cpu_gnt && bus.dbg_gnt)
                check("gnt_onehot", 32'd1, 32'd0);
            if (bus.mem_en) begin
                if (mq.size() == 0) begin
                    check("mem_en_unexpected", 32'd1, 32'd0);
                end else begin
                    me = mq.pop_front();
                    check("mem_en_cycle", 32'(cyc), 32'(me.cyc));
                    check("mem_we", 32'(bus.mem_we), 32'(me.we));
                    check("mem_addr", bus.mem_addr, me.addr);
                    if (me.we)
                        check("mem_wdata", bus.mem_wdata, me.wdata);
                end
            end
            if (bus.cpu_rvalid || bus.dbg_rvalid) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rq.pop_front();
                    check("rvalid_cycle", 32'(cyc), 32'(re.cyc));
                    check("rvalid_cpu", 32'(bus.cpu_rvalid), 32'(!re.dbg));
                    check("rvalid_dbg", 32'(bus.dbg_rvalid), 32'(re.dbg));
                    check("rdata", re.dbg ? bus.dbg_rdata : bus.cpu_rdata,
                          re.rdata);
                end
            end
        end
    end

    // Monitor for the LAT=3 instance
    always @(negedge clk) begin
        mem_exp_t me;
        rsp_exp_t re;
        if (rst_n) begin
            if (bus3.mem_en) begin
                if (mq3.size() == 0) begin
                    check("l3_mem_en_unexpected", 32'd1, 32'd0);
                end else begin
                    me = mq3.pop_front();
                    check("l3_mem_en_cycle", 32'(cyc), 32'(me.cyc));
                    check("l3_mem_addr", bus3.mem_addr, me.addr);
                end
            end
            if (bus3.cpu_rvalid || bus3.dbg_rvalid) begin
                if (rq3.size() == 0) begin
                    check("l3_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rq3.pop_front();
                    check("l3_rvalid_cycle", 32'(cyc), 32'(re.cyc));
                    check("l3_rvalid_cpu", 32'(bus3.cpu_rvalid), 32'd1);
                    check("l3_rdata", bus3.cpu_rdata, re.rdata);
                end
            end
        end
    end

    // Record what a granted access must produce
    task automatic push_exp(input logic dbg, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int tg);
        logic [31:0] rd;
        if (we) begin
            rd = dbg ? last_rd_dbg : last_rd_cpu;
            shadow[addr[7:2]] = wdata;
        end else begin
            rd = shadow[addr[7:2]];
            if (dbg) last_rd_dbg = rd;
            else last_rd_cpu = rd;
        end
        mq.push_back('{tg + 1, we, addr, wdata});
        rq.push_back('{tg + 2 + LAT, dbg, rd});
    endtask

    // Issue one request (called just after a rising edge), wait for gnt
    task automatic do_access(input logic dbg, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int nwait);
        bit got;
        got = 0;
        nwait = 0;
        if (dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we;
            bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we;
            bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        while (!got && nwait < 40) begin
            @(negedge clk);
            if (dbg ? bus.dbg_gnt : bus.cpu_gnt) got = 1;
            else nwait++;
        end
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
        end else begin
            push_exp(dbg, we, addr, wdata, cyc);
        end
        @(posedge clk);
        #1;
        if (dbg) begin
            bus.dbg_req = 1'b0; bus.dbg_we = ~we;
            bus.dbg_addr = 32'd88; bus.dbg_wdata = ~wdata;
        end else begin
            bus.cpu_req = 1'b0; bus.cpu_we = ~we;
            bus.cpu_addr = 32'd88; bus.cpu_wdata = ~wdata;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || rq.size() != 0 ||
                mq3.size() != 0 || rq3.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(mq.size() + rq.size() + mq3.size() + rq3.size()),
              32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int       nw;
        int       prev;
        bit       got;
        logic     exp_dbg;
        mem_mq_dummy: begin end
        for (int i = 0; i < 64; i++)
            shadow[i] = (i == 20) ? 32'h12345678 : (32'hA5000000 | 32'(i));
        bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0;
        bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.dbg_req = 0; bus3.dbg_we = 0;
        bus3.dbg_addr = 0; bus3.dbg_wdata = 0;

        // Reset state, with both requests raised to prove gnt is forced low
        bus.cpu_req = 1'b1;
        bus.dbg_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rvalid", 32'({bus.cpu_rvalid, bus.dbg_rvalid}), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // cpu write 84 <- 7; addr is changed to 88 right after gnt
        do_access(1'b0, 1'b1, 32'd84, 32'd7, nw);
        check("t1_gnt_first_cycle", 32'(nw), 32'd0);
        wait_drain();

        // cpu read-back of 84
        do_access(1'b0, 1'b0, 32'd84, 32'd0, nw);
        wait_drain();

        // cpu write acknowledge leaves cpu_rdata at 7
        do_access(1'b0, 1'b1, 32'd84, 32'd9, nw);
        wait_drain();

        // dbg read 80 returns 0x12345678
        do_access(1'b1, 1'b0, 32'd80, 32'd0, nw);
        check("t2_gnt_first_cycle", 32'(nw), 32'd0);
        wait_drain();

        // Both requesting continuously: grant order and spacing
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd8;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'd12;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            nw = 0;
            while (!got && nw < 20) begin
                @(negedge clk);
                if (bus.cpu_gnt || bus.dbg_gnt) got = 1;
                else nw++;
            end
            if (!got) begin
                check("t3_gnt_timeout", 32'd0, 32'd1);
            end else begin
`ifdef ROUND_ROBIN_EN
                exp_dbg = 1'(k % 2);
`else
                exp_dbg = 1'b0;
`endif
                check("t3_winner", 32'(bus.dbg_gnt), 32'(exp_dbg));
                if (k > 0)
                    check("t3_spacing", 32'(cyc - prev), 32'(3 + LAT));
                prev = cyc;
                push_exp(bus.dbg_gnt, 1'b0,
                         bus.dbg_gnt ? bus.dbg_addr : bus.cpu_addr,
                         32'd0, cyc);
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        wait_drain();

        // Reset during WAIT abandons the cpu read of 16
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd16;
        @(negedge clk);
        check("t4_gnt", 32'(bus.cpu_gnt), 32'd1);
        mq.push_back('{cyc + 1, 1'b0, 32'd16, 32'd0});
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.cpu_req = 1'b1;
        bus.dbg_req = 1'b1;
        #1;
        check("t4_mem_en", 32'(bus.mem_en), 32'd0);
        check("t4_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("t4_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        check("t4_rvalid", 32'({bus.cpu_rvalid, bus.dbg_rvalid}), 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        last_rd_cpu = 32'h0;
        last_rd_dbg = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_no_rvalid",
                  32'({bus.cpu_rvalid, bus.dbg_rvalid}), 32'd0);
        end
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'd80, 32'd0, nw);
        check("t4_gnt_first_cycle", 32'(nw), 32'd0);
        wait_drain();

        // MEM_LAT=3 instance: cpu read of 4
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'd4;
        got = 0;
        nw = 0;
        while (!got && nw < 20) begin
            @(negedge clk);
            if (bus3.cpu_gnt) got = 1;
            else nw++;
        end
        if (!got) begin
            check("t5_gnt_timeout", 32'd0, 32'd1);
        end else begin
            check("t5_gnt_first_cycle", 32'(nw), 32'd0);
            mq3.push_back('{cyc + 1, 1'b0, 32'd4, 32'd0});
            rq3.push_back('{cyc + 2 + LAT3, 1'b0, 32'hC0DE0004});
        end
        @(posedge clk);
        #1;
        bus3.cpu_req = 1'b0;
        bus3.cpu_addr = 32'd88;
        wait_drain();

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
